mb_pattern_compare_ctrl: RTL and testbench



---
 rtl/mb_pattern_compare_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mb_pattern_compare_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mb_pattern_compare_ctrl.sv
// Mainband pattern-comparator sequencer: clear, run N deserializer bursts, latch
// the comparator verdict and report pass/fail, with abort and burst watchdog.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for i_start; comparator idle
//   S_CLEAR  | comparator held in CLEAR_LFSR for CLR_CYCLES cycles
//   S_RUN    | comparing; counting burst falling edges, watchdog running
//   S_LATCH  | one settle cycle so the comparator latches its own verdict
//   S_REPORT | one-cycle o_done with results loaded
module mb_pattern_compare_ctrl #(
  parameter int ITER_W         = 8,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  input  logic [ITER_W-1:0] i_num_bursts,
  input  logic [15:0]       i_lane_mask,
  input  logic              i_enable_buffer,
  input  logic [15:0]       i_per_lane_error,
  input  logic              i_error_done,
  output logic [1:0]        o_cmp_state,
  output logic              o_cmp_enable,
  output logic              o_cmp_type,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [15:0]       o_lane_result,
  output logic              o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_LATCH  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t              state, next_state;
  logic [1:0]          mode_q;
  logic [ITER_W-1:0]   num_q;
  logic [15:0]         mask_q;
  logic [CLR_W-1:0]    clr_cnt;
  logic [ITER_W-1:0]   burst_cnt;
  logic [TIMEOUT_W-1:0] wdog;
  logic                en_q;
  logic                fall, burst_last, wd_fire, per_lane;

  assign fall       = en_q & ~i_enable_buffer;
  assign burst_last = (burst_cnt + ITER_W'(1)) == num_q;
  assign wd_fire    = (wdog == WD_LAST);
  assign per_lane   = (mode_q == 2'b01) || (mode_q == 2'b10);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (i_start) next_state = (i_mode == 2'b11) ? S_REPORT : S_CLEAR;
      S_CLEAR:  if (clr_cnt == '0) next_state = S_RUN;
      S_RUN: begin
        // a burst edge outranks a watchdog expiry in the same cycle
        if (fall) begin
          if (burst_last) next_state = S_LATCH;
        end else if (wd_fire) begin
          next_state = S_REPORT;
        end
      end
      S_LATCH:  next_state = S_REPORT;
      S_REPORT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (i_abort && state != S_IDLE) next_state = S_IDLE;
  end

  always_comb begin
    o_cmp_state  = 2'b00;
    o_cmp_enable = 1'b0;
    o_cmp_type   = (state != S_IDLE) && per_lane;
    o_busy       = (state != S_IDLE);
    o_done       = (state == S_REPORT);
    unique case (state)
      S_CLEAR: begin
        o_cmp_state  = 2'b01;
        o_cmp_enable = 1'b1;
      end
      S_RUN, S_LATCH: begin
        o_cmp_state  = (mode_q == 2'b10) ? 2'b11 : 2'b10;
        o_cmp_enable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q      <= 1'b0;
      mode_q    <= 2'b00;
      num_q     <= '0;
      mask_q    <= '0;
      clr_cnt   <= '0;
      burst_cnt <= '0;
      wdog      <= '0;
    end else begin
      en_q <= i_enable_buffer;
      if (state == S_IDLE && i_start) begin
        mode_q  <= i_mode;
        num_q   <= (i_num_bursts == '0) ? ITER_W'(1) : i_num_bursts;
        mask_q  <= i_lane_mask;
        clr_cnt <= CLR_LAST;
      end else if (state == S_CLEAR && clr_cnt != '0) begin
        clr_cnt <= clr_cnt - CLR_W'(1);
      end
      if (state == S_RUN) begin
        if (fall) begin
          burst_cnt <= burst_cnt + ITER_W'(1);
          wdog      <= '0;
        end else begin
          wdog <= wdog + TIMEOUT_W'(1);
        end
      end else begin
        burst_cnt <= '0;
        wdog      <= '0;
      end
    end
  end

  // results only move on REPORT entry, so an abort leaves the last verdict intact
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pass        <= 1'b0;
      o_lane_result <= '0;
      o_timeout     <= 1'b0;
    end else if (next_state == S_REPORT) begin
      if (state == S_LATCH) begin
        o_timeout <= 1'b0;
        if (per_lane) begin
          o_lane_result <= i_per_lane_error;
          o_pass        <= &(i_per_lane_error | ~mask_q);
        end else begin
          o_lane_result <= {16{i_error_done}};
          o_pass        <= i_error_done;
        end
      end else begin
        o_pass        <= 1'b0;
        o_lane_result <= '0;
        o_timeout     <= (state == S_RUN);
      end
    end
  end

endmodule

// File: tb/tb_mb_pattern_compare_ctrl.sv
// Self-checking bench for mb_pattern_compare_ctrl: directed scenarios plus
// randomized runs checked against a lane-by-lane verdict model.
module tb_mb_pattern_compare_ctrl;
  localparam int TO  = 100;
  localparam int CLR = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [1:0]  i_mode = 2'b00;
  logic [7:0]  i_num_bursts = 8'd0;
  logic [15:0] i_lane_mask = 16'h0;
  logic        i_enable_buffer = 1'b0;
  logic [15:0] i_per_lane_error = 16'h0;
  logic        i_error_done = 1'b0;
  logic [1:0]  o_cmp_state;
  logic        o_cmp_enable, o_cmp_type, o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_lane_result;

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic        exp_pass = 1'b0;
  logic [15:0] exp_lane = 16'h0;
  logic        exp_to = 1'b0;

  mb_pattern_compare_ctrl #(
    .ITER_W(8), .CLR_CYCLES(CLR), .TIMEOUT_W(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_mode(i_mode), .i_num_bursts(i_num_bursts), .i_lane_mask(i_lane_mask),
    .i_enable_buffer(i_enable_buffer), .i_per_lane_error(i_per_lane_error),
    .i_error_done(i_error_done), .o_cmp_state(o_cmp_state),
    .o_cmp_enable(o_cmp_enable), .o_cmp_type(o_cmp_type), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_lane_result(o_lane_result),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // verdict from the lane rules: a masked-in lane that is not good fails the test
  function automatic void model(input logic [1:0] mode, input logic [15:0] mask,
                                input logic [15:0] ple, input logic ed,
                                output logic p, output logic [15:0] l);
    if (mode == 2'b00) begin
      p = ed;
      for (int i = 0; i < 16; i++) l[i] = ed;
    end else begin
      p = 1'b1;
      l = ple;
      for (int i = 0; i < 16; i++) if (mask[i] && !ple[i]) p = 1'b0;
    end
  endfunction

  task automatic chk_held(input string tag);
    chk({tag, "_pass"}, {31'd0, o_pass}, {31'd0, exp_pass});
    chk({tag, "_lane"}, {16'd0, o_lane_result}, {16'd0, exp_lane});
    chk({tag, "_timeout"}, {31'd0, o_timeout}, {31'd0, exp_to});
  endtask

  task automatic go_start(input logic [1:0] mode, input logic [7:0] num, input logic [15:0] mask);
    i_mode = mode; i_num_bursts = num; i_lane_mask = mask; i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_mode = 2'($urandom); i_num_bursts = 8'($urandom); i_lane_mask = 16'($urandom);
  endtask

  task automatic run_test(input logic [1:0] mode, input logic [7:0] num, input logic [15:0] mask,
                          input logic [15:0] ple, input logic ed, input int blen);
    int nb;
    logic [1:0] run_st;
    logic typ;
    nb = (num == 8'd0) ? 1 : int'(num);
    run_st = (mode == 2'b10) ? 2'b11 : 2'b10;
    typ = (mode == 2'b01) || (mode == 2'b10);
    i_per_lane_error = 16'($urandom); i_error_done = 1'($urandom);
    go_start(mode, num, mask);
    for (int c = 0; c < CLR; c++) begin
      chk("clear_state", {30'd0, o_cmp_state}, 32'd1);
      chk("clear_en", {31'd0, o_cmp_enable}, 32'd1);
      chk("clear_type", {31'd0, o_cmp_type}, {31'd0, typ});
      step();
    end
    for (int b = 0; b < nb; b++) begin
      int len;
      len = (blen > 0) ? blen : int'($urandom_range(1, 6));
      chk("run_state", {30'd0, o_cmp_state}, {30'd0, run_st});
      chk("run_done", {31'd0, o_done}, 32'd0);
      i_enable_buffer = 1'b1;
      repeat (len) step();
      i_enable_buffer = 1'b0;
      i_per_lane_error = 16'($urandom); i_error_done = 1'($urandom);
      step();
      if (b < nb - 1) repeat ($urandom_range(0, 2)) step();
    end
    chk("latch_state", {30'd0, o_cmp_state}, {30'd0, run_st});
    chk("latch_en", {31'd0, o_cmp_enable}, 32'd1);
    chk("latch_done", {31'd0, o_done}, 32'd0);
    i_per_lane_error = ple; i_error_done = ed;
    step();
    i_per_lane_error = 16'($urandom); i_error_done = 1'($urandom);
    model(mode, mask, ple, ed, exp_pass, exp_lane);
    exp_to = 1'b0;
    chk("report_done", {31'd0, o_done}, 32'd1);
    chk("report_state", {30'd0, o_cmp_state}, 32'd0);
    chk("report_en", {31'd0, o_cmp_enable}, 32'd0);
    chk("report_type", {31'd0, o_cmp_type}, {31'd0, typ});
    chk_held("report");
    step();
    chk("idle_done", {31'd0, o_done}, 32'd0);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk_held("idle");
  endtask

  task automatic timeout_test(input int pre_len);
    int n;
    go_start(2'b01, 8'd2, 16'hFFFF);
    repeat (CLR) step();
    if (pre_len > 0) begin
      i_enable_buffer = 1'b1;
      repeat (pre_len) step();
      i_enable_buffer = 1'b0;
      step();
    end
    n = 0;
    while (!o_done && n < 3 * TO) begin
      step();
      n++;
    end
    chk("timeout_latency", n, TO);
    exp_pass = 1'b0; exp_lane = 16'h0; exp_to = 1'b1;
    chk_held("timeout");
    step();
    chk("timeout_idle", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_state", {30'd0, o_cmp_state}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_en", {31'd0, o_cmp_enable}, 32'd0);
    chk_held("rst");
    i_rst_n = 1'b1;
    step();

    run_test(2'b01, 8'd3, 16'hFFFF, 16'hFFFF, 1'b0, 8);
    run_test(2'b10, 8'd1, 16'hFF7F, 16'hFF7F, 1'b0, 0);
    run_test(2'b10, 8'd1, 16'hFFFF, 16'hFF7F, 1'b1, 0);
    run_test(2'b00, 8'd0, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    timeout_test(0);
    timeout_test(3);

    for (int k = 0; k < 12; k++) begin
      logic [1:0] m;
      logic [15:0] msk, ple;
      m = 2'($urandom_range(0, 2));
      msk = 16'($urandom);
      ple = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ple = ple | msk;
      run_test(m, 8'($urandom_range(0, 4)), msk, ple, 1'($urandom), 0);
    end

    // abort mid-run with a start attempt while busy
    run_test(2'b01, 8'd1, 16'hFFFF, 16'hA5A5, 1'b0, 0);
    go_start(2'b01, 8'd4, 16'hFFFF);
    repeat (CLR) step();
    i_enable_buffer = 1'b1;
    repeat (3) step();
    i_enable_buffer = 1'b0;
    step();
    i_mode = 2'b11; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("busy_start_state", {30'd0, o_cmp_state}, 32'd2);
    chk("busy_start_done", {31'd0, o_done}, 32'd0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_en", {31'd0, o_cmp_enable}, 32'd0);
    chk("abort_done", {31'd0, o_done}, 32'd0);
    chk_held("abort");
    step();
    chk("abort_done2", {31'd0, o_done}, 32'd0);

    // illegal mode reports straight away
    i_per_lane_error = 16'hFFFF; i_error_done = 1'b1;
    go_start(2'b11, 8'd2, 16'hFFFF);
    exp_pass = 1'b0; exp_lane = 16'h0; exp_to = 1'b0;
    chk("illegal_done", {31'd0, o_done}, 32'd1);
    chk("illegal_busy", {31'd0, o_busy}, 32'd1);
    chk_held("illegal");
    step();
    chk("illegal_idle", {31'd0, o_done}, 32'd0);

    // async reset in the middle of CLEAR
    run_test(2'b00, 8'd1, 16'h0, 16'h0, 1'b1, 0);
    go_start(2'b10, 8'd2, 16'hFFFF);
    #2;
    i_rst_n = 1'b0;
    #1;
    exp_pass = 1'b0; exp_lane = 16'h0; exp_to = 1'b0;
    chk("rst_mid_state", {30'd0, o_cmp_state}, 32'd0);
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_mid_en", {31'd0, o_cmp_enable}, 32'd0);
    chk("rst_mid_type", {31'd0, o_cmp_type}, 32'd0);
    chk_held("rst_mid");
    step();
    i_rst_n = 1'b1;
    step();
    run_test(2'b01, 8'd2, 16'h00FF, 16'h12FF, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
